// File: rtl/int_to_float_if.sv
// rtl/int_to_float_if.sv - valid/ready bus between an integer producer, int_to_float and a float consumer
//
// Purpose: bundles the input (integer) and output (float) handshakes of int_to_float.
// Signals:
//   in_valid  producer -> converter  in_data is valid
//   in_ready  converter -> producer  converter can accept an input this cycle
//   in_data   producer -> converter  signed two's-complement integer, INT_WIDTH bits
//   out_valid converter -> consumer  out_data holds a result
//   out_ready consumer -> converter  consumer accepts the result this cycle
//   out_data  converter -> consumer  {sign, exponent, mantissa}, EXPONENT+MANTISSA+1 bits
// Modports: master = producer/consumer side (testbench), slave = converter side.
interface int_to_float_if #(
  parameter int INT_WIDTH = 16,
  parameter int EXPONENT  = 6,
  parameter int MANTISSA  = 11
);
  logic                         in_valid;
  logic                         in_ready;
  logic [INT_WIDTH-1:0]         in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [EXPONENT+MANTISSA:0]   out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/int_to_float.sv
// rtl/int_to_float.sv - iterative signed integer to custom float converter
//
// Purpose: converts a signed INT_WIDTH-bit integer into {sign, EXPONENT, MANTISSA}
// with a hidden leading one, normalising one bit per cycle and rounding to nearest
// with ties away from zero. Exponent overflow saturates to the largest magnitude.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      int_to_float_if.slave: in_valid/in_ready/in_data, out_valid/out_ready/out_data
module int_to_float #(
  parameter int INT_WIDTH = 16,
  parameter int EXPONENT  = 6,
  parameter int MANTISSA  = 11
) (
  input  logic          clk,
  input  logic          reset_n,
  int_to_float_if.slave bus
);
  localparam int BIAS    = 2**(EXPONENT-1) - 1;
  localparam int EXP_MAX = 2**EXPONENT - 1;
  localparam int LZW     = $clog2(INT_WIDTH + 1);
  localparam int OW      = EXPONENT + MANTISSA + 1;
  localparam int FW      = INT_WIDTH + MANTISSA;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t               state, state_nxt;
  logic                 sign;
  logic [INT_WIDTH-1:0] mag;
  logic [LZW-1:0]       lz;
  logic [OW-1:0]        out_q;

  logic [INT_WIDTH-1:0] mag_in;
  logic                 in_zero;
  logic [MANTISSA:0]    window;
  logic [MANTISSA-1:0]  mant_r;
  logic                 carry;
  logic [31:0]          exp_b;
  logic [OW-1:0]        round_word;

  // Two's-complement magnitude; the most negative input wraps to 2^(INT_WIDTH-1),
  // which is exactly right when read as unsigned.
  assign mag_in  = bus.in_data[INT_WIDTH-1] ? (~bus.in_data + 1'b1) : bus.in_data;
  assign in_zero = (bus.in_data == '0);

  // Rounding datapath, valid once mag is normalised (msb set).
  always_comb begin
    // Bits below the hidden one, zero-padded on the right; top MANTISSA bits are
    // the mantissa and the bit after them is the guard.
    window = (MANTISSA+1)'({mag[INT_WIDTH-2:0], {(MANTISSA+1){1'b0}}} >> (INT_WIDTH-1));
    {carry, mant_r} = {1'b0, window[MANTISSA:1]} + (MANTISSA+1)'(window[0]);
    exp_b = 32'(INT_WIDTH - 1 + BIAS) - 32'(lz) + 32'(carry);
    if (exp_b > 32'(EXP_MAX))
      round_word = {sign, {EXPONENT{1'b1}}, {MANTISSA{1'b1}}};
    else
      round_word = {sign, exp_b[EXPONENT-1:0], mant_r};
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.in_valid) state_nxt = in_zero ? DONE : NORM;
      NORM:  if (mag[INT_WIDTH-1]) state_nxt = ROUND;
      ROUND: state_nxt = DONE;
      DONE:  if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  assign bus.out_data = out_q;

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sign  <= 1'b0;
      mag   <= '0;
      lz    <= '0;
      out_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sign <= bus.in_data[INT_WIDTH-1];
          mag  <= mag_in;
          lz   <= '0;
          if (in_zero) out_q <= '0;
        end
        NORM: if (!mag[INT_WIDTH-1]) begin
          mag <= mag << 1;
          lz  <= lz + 1'b1;
        end
        ROUND: out_q <= round_word;
        default: ;
      endcase
    end
  end
endmodule
